counter_ctrl: RTL and testbench

- Run/sequence controller for the 8-bit up/down binary counter on the board.
- Takes raw push-button commands and a limit configuration, and generates a 1 s tick as a clock-enable in the single 100 MHz domain.
- Drives the counter's CE, UP and SCLR inputs, and watches the count value it returns so it can apply stop or bounce behaviour at programmable limits.

---
 rtl/counter_ctrl_pkg.sv | 22 ++
 rtl/btn_sync_edge.sv | 27 ++
 rtl/counter_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the up/down counter run controller.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_STOP   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   localparam int DEFAULT_TICK_DIV = 100000000;

   // A bad limit window, or the spare mode code, both behave as plain wrap.
   function automatic logic [1:0] eff_mode(input logic [1:0] mode, input logic cfg_err);
      return (cfg_err || mode == 2'b11) ? MODE_WRAP : mode;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw push-button followed by a rising-edge pulse.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_btn;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/halt sequencer that paces an external up/down counter with a divided tick
// and applies wrap, stop-at-limit or bounce behaviour against its fed-back count.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV,
   parameter int WIDTH    = 8
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             btn_start,
   input  logic             btn_stop,
   input  logic             btn_dir,
   input  logic             btn_clear,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lo_limit,
   input  logic [WIDTH-1:0] hi_limit,
   input  logic [WIDTH-1:0] count,
   output logic             cnt_ce,
   output logic             cnt_up,
   output logic             cnt_sclr,
   output logic             tick,
   output logic [1:0]       state,
   output logic             cfg_err
);

   localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int EV_START = 0;
   localparam int EV_DIR   = 1;
   localparam int EV_STOP  = 2;
   localparam int EV_CLEAR = 3;

   logic [3:0]       w_btn;
   logic [3:0]       w_ev;
   logic [1:0]       w_mode;
   logic             w_up_dir;
   logic             w_hit_cur;
   logic             w_hit_new;
   logic             w_div_end;
   logic             w_start;

   state_t           r_state;
   logic             r_cnt_up;
   logic             r_cnt_ce;
   logic             r_cnt_sclr;
   logic             r_tick;
   logic [DIV_W-1:0] r_div;

   assign w_btn = {btn_clear, btn_stop, btn_dir, btn_start};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         btn_sync_edge u_sync (
            .i_clk   (clk_100MHz),
            .i_rst_n (reset),
            .i_btn   (w_btn[gi]),
            .o_pulse (w_ev[gi])
         );
      end
   endgenerate

   assign cfg_err   = (lo_limit >= hi_limit);
   assign w_mode    = eff_mode(mode, cfg_err);
   assign w_up_dir  = r_cnt_up ^ w_ev[EV_DIR];
   assign w_hit_cur = r_cnt_up ? (count == hi_limit) : (count == lo_limit);
   // HALT is re-evaluated with any direction change arriving in the same cycle.
   assign w_hit_new = w_up_dir ? (count == hi_limit) : (count == lo_limit);
   assign w_div_end = (r_div == DIV_W'(TICK_DIV - 1));
   // Stop outranks start, so a simultaneous stop masks start in every state.
   assign w_start   = w_ev[EV_START] & ~w_ev[EV_STOP];

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt_up   <= 1'b1;
         r_cnt_ce   <= 1'b0;
         r_cnt_sclr <= 1'b0;
         r_tick     <= 1'b0;
         r_div      <= '0;
      end else begin
         r_cnt_ce   <= 1'b0;
         r_cnt_sclr <= 1'b0;
         r_tick     <= 1'b0;
         if (w_ev[EV_CLEAR]) begin
            r_cnt_sclr <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt_up   <= 1'b1;
            r_div      <= '0;
         end else begin
            r_cnt_up <= w_up_dir;
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state <= ST_RUN;
                     r_div   <= '0;
                  end
               end
               ST_PAUSE: begin
                  if (w_start) r_state <= ST_RUN;
               end
               ST_HALT: begin
                  if (w_start && !(w_mode == MODE_STOP && w_hit_new)) r_state <= ST_RUN;
               end
               ST_RUN: begin
                  if (w_ev[EV_STOP]) begin
                     r_state <= ST_PAUSE;
                  end else if (w_div_end) begin
                     r_tick <= 1'b1;
                     r_div  <= '0;
                     if (w_mode == MODE_STOP && w_hit_cur) begin
                        r_state <= ST_HALT;
                     end else begin
                        r_cnt_ce <= 1'b1;
                        if (w_mode == MODE_BOUNCE && w_hit_cur) r_cnt_up <= ~w_up_dir;
                     end
                  end else begin
                     r_div <= r_div + DIV_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign cnt_ce   = r_cnt_ce;
   assign cnt_up   = r_cnt_up;
   assign cnt_sclr = r_cnt_sclr;
   assign tick     = r_tick;
   assign state    = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed and randomized bench for counter_ctrl against a cycle-level behavioural model.
module tb_counter_ctrl;

   localparam int TD     = 4;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_PAUS = 2;
   localparam int S_HALT = 3;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       b_start = 1'b0;
   logic       b_stop  = 1'b0;
   logic       b_dir   = 1'b0;
   logic       b_clear = 1'b0;
   logic [1:0] mode    = 2'b00;
   logic [7:0] lo      = 8'd2;
   logic [7:0] hi      = 8'd5;
   logic [7:0] count;
   logic       cnt_ce, cnt_up, cnt_sclr, tick, cfg_err;
   logic [1:0] state;

   int n_vec = 0;
   int n_err = 0;

   int m_state, m_div, m_count;
   bit m_up, m_ce, m_sclr, m_tick;
   bit [2:0] h_start, h_stop, h_dir, h_clear;

   counter_ctrl #(.TICK_DIV(TD), .WIDTH(8)) dut (
      .clk_100MHz (clk),
      .reset      (rst_n),
      .btn_start  (b_start),
      .btn_stop   (b_stop),
      .btn_dir    (b_dir),
      .btn_clear  (b_clear),
      .mode       (mode),
      .lo_limit   (lo),
      .hi_limit   (hi),
      .count      (count),
      .cnt_ce     (cnt_ce),
      .cnt_up     (cnt_up),
      .cnt_sclr   (cnt_sclr),
      .tick       (tick),
      .state      (state),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   // The board counter being controlled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        count <= 8'd0;
      else if (cnt_sclr) count <= 8'd0;
      else if (cnt_ce)   count <= cnt_up ? count + 8'd1 : count - 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_div = 0; m_count = 0;
      m_up = 1'b1; m_ce = 1'b0; m_sclr = 1'b0; m_tick = 1'b0;
      h_start = '0; h_stop = '0; h_dir = '0; h_clear = '0;
   endtask

   // One clock edge: predict, advance, compare every output.
   task automatic step();
      bit e_clr, e_stop, e_start, e_dir, cfge, stopm, bouncem, hit, nu, nce, nsc, nt;
      int ns, nd, nc;
      e_clr   = h_clear[1] & ~h_clear[2];
      e_stop  = h_stop[1]  & ~h_stop[2];
      e_start = h_start[1] & ~h_start[2];
      e_dir   = h_dir[1]   & ~h_dir[2];
      cfge    = (lo >= hi);
      stopm   = !cfge && (mode == 2'd1);
      bouncem = !cfge && (mode == 2'd2);
      nc  = m_sclr ? 0 : (m_ce ? (m_count + (m_up ? 1 : 255)) % 256 : m_count);
      hit = m_up ? (m_count == int'(hi)) : (m_count == int'(lo));
      ns = m_state; nd = m_div; nu = m_up; nce = 0; nsc = 0; nt = 0;
      if (e_clr) begin
         nsc = 1; ns = S_IDLE; nu = 1; nd = 0;
      end else begin
         if (e_dir) nu = !m_up;
         if (m_state == S_IDLE && e_start && !e_stop) begin
            ns = S_RUN; nd = 0;
         end else if (m_state == S_PAUS && e_start && !e_stop) begin
            ns = S_RUN;
         end else if (m_state == S_HALT && e_start && !e_stop) begin
            if (!(stopm && (nu ? (m_count == int'(hi)) : (m_count == int'(lo))))) ns = S_RUN;
         end else if (m_state == S_RUN) begin
            if (e_stop) ns = S_PAUS;
            else begin
               nd = (m_div + 1) % TD;
               if (nd == 0) begin
                  nt = 1;
                  if (stopm && hit) ns = S_HALT;
                  else begin
                     nce = 1;
                     if (bouncem && hit) nu = !nu;
                  end
               end
            end
         end
      end
      h_start = {h_start[1:0], b_start};
      h_stop  = {h_stop[1:0],  b_stop};
      h_dir   = {h_dir[1:0],   b_dir};
      h_clear = {h_clear[1:0], b_clear};
      @(posedge clk);
      #1;
      m_state = ns; m_div = nd; m_up = nu; m_ce = nce; m_sclr = nsc; m_tick = nt; m_count = nc;
      chk("state", state, m_state);
      chk("cnt_ce", cnt_ce, m_ce);
      chk("cnt_up", cnt_up, m_up);
      chk("cnt_sclr", cnt_sclr, m_sclr);
      chk("tick", tick, m_tick);
      chk("count", count, m_count);
      chk("cfg_err", cfg_err, cfge);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic press(input bit s, input bit st, input bit d, input bit c);
      b_start = s; b_stop = st; b_dir = d; b_clear = c;
      step();
      b_start = 0; b_stop = 0; b_dir = 0; b_clear = 0;
      step();
   endtask

   task automatic run_until(input string tag, input logic [7:0] target, input int maxc);
      int k = 0;
      while (count !== target && k < maxc) begin
         step();
         k++;
      end
      chk(tag, count, target);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, state, S_IDLE);
      chk({tag, "_up"}, cnt_up, 1);
      chk({tag, "_ce"}, cnt_ce, 0);
      chk({tag, "_sclr"}, cnt_sclr, 0);
      chk({tag, "_tick"}, tick, 0);
   endtask

   // Assert reset between clock edges, check outputs at once, release later.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      b_start = 0; b_stop = 0; b_dir = 0; b_clear = 0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_reset_values("por");
      rst_n = 1'b1;

      // Wrap mode basic counting.
      press(1, 0, 0, 0);
      step();
      chk("start_run", state, S_RUN);
      run(13);
      chk("count_3", count, 3);

      // Wrap boundary downward then upward.
      press(0, 0, 0, 1);
      step();
      step();
      press(0, 0, 1, 0);
      step();
      chk("dir_down", cnt_up, 0);
      press(1, 0, 0, 0);
      step();
      run_until("wrap_255", 8'd255, 20);
      press(0, 0, 1, 0);
      run_until("wrap_0", 8'd0, 20);

      // Stop-at-limit.
      press(0, 0, 0, 1);
      step();
      mode = 2'd1; lo = 8'd2; hi = 8'd5;
      step();
      press(1, 0, 0, 0);
      step();
      run_until("stop_hi", 8'd5, 40);
      run(10);
      chk("halt_state", state, S_HALT);
      chk("halt_count", count, 5);
      press(1, 0, 0, 0);
      step();
      chk("halt_ignore", state, S_HALT);
      press(0, 0, 1, 0);
      step();
      press(1, 0, 0, 0);
      step();
      chk("halt_resume", state, S_RUN);
      run_until("resume_4", 8'd4, 12);

      // Bounce between limits.
      press(0, 0, 0, 1);
      step();
      mode = 2'd2;
      press(1, 0, 0, 0);
      step();
      run_until("bounce_5", 8'd5, 40);
      run_until("bounce_2", 8'd2, 30);
      chk("bounce_dn", cnt_up, 0);
      run_until("bounce_3", 8'd3, 12);
      chk("bounce_up", cnt_up, 1);

      // Clear, stop and dir together while running.
      press(0, 1, 1, 1);
      step();
      chk("combo_sclr", cnt_sclr, 1);
      chk("combo_idle", state, S_IDLE);
      chk("combo_up", cnt_up, 1);
      run(10);

      // Pause and resume keep the divider phase.
      mode = 2'd0;
      press(1, 0, 0, 0);
      step();
      run(2);
      press(0, 1, 0, 0);
      step();
      chk("paused", state, S_PAUS);
      run(5);
      press(1, 0, 0, 0);
      step();
      chk("resumed", state, S_RUN);
      run(8);

      // Asynchronous reset in the middle of RUN.
      run(3);
      async_reset();

      // Inverted limits force wrap behaviour even in stop mode.
      lo = 8'd7; hi = 8'd3; mode = 2'd1;
      step();
      chk("cfg_err_hi", cfg_err, 1);
      press(1, 0, 0, 0);
      step();
      run(60);
      chk("cfg_wrap_run", state, S_RUN);

      // Randomized buttons, modes and limits.
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            mode = 2'($urandom_range(0, 3));
            lo   = 8'($urandom_range(0, 12));
            hi   = 8'($urandom_range(0, 20));
         end
         if ($urandom_range(0, 5) == 0)  b_start = ~b_start;
         if ($urandom_range(0, 29) == 0) b_stop  = ~b_stop;
         if ($urandom_range(0, 19) == 0) b_dir   = ~b_dir;
         if ($urandom_range(0, 79) == 0) b_clear = ~b_clear;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
